// File: rtl/m_result_tx_pkg.sv
// rtl/m_result_tx_pkg.sv - shared constants, FSM encoding and nibble-to-ASCII helper for the result reporter
package m_result_tx_pkg;

  localparam int TX_COUNT_DEF = 50;
  localparam int MSG_LEN      = 19;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic [7:0] f_nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    else             return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/m_result_tx_uart.sv
// rtl/m_result_tx_uart.sv - 8N1 byte serializer; accepts the next byte in the last stop-bit cycle so frames run back-to-back
module m_UartTx #(
  parameter int TX_COUNT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_txd
);

  localparam int             DW       = (TX_COUNT > 1) ? $clog2(TX_COUNT) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(TX_COUNT - 1);

  logic          busy_q, busy_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (div_q == DIV_LAST);
  assign o_txd   = txd_q;

  // bit_q: 0 = start, 1..8 = data, 9 = stop; sh_q carries data then the stop '1'
  always_comb begin
    o_ready = !busy_q || (bit_end && (bit_q == 4'd9));
    busy_d  = busy_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    if (i_valid && o_ready) begin
      busy_d = 1'b1;
      div_d  = '0;
      bit_d  = '0;
      sh_d   = {1'b1, i_data};
      txd_d  = 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        div_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          txd_d = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      txd_q  <= 1'b1;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      txd_q  <= txd_d;
    end
  end

endmodule

// File: rtl/m_result_tx.sv
// rtl/m_result_tx.sv - on a trigger edge, snapshots result and cycle count and sends them as hex text over UART
module m_result_tx
  import m_result_tx_pkg::*;
#(
  parameter int TX_COUNT = TX_COUNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_trig,
  input  logic [31:0] i_rout,
  input  logic [31:0] i_ccnt,
  output logic        o_txd,
  output logic        o_busy,
  output logic        o_done
);

  state_e      state_q, state_d;
  logic [4:0]  byte_idx_q, byte_idx_d;
  logic        last_q, last_d;
  logic [31:0] rout_q, rout_d;
  logic [31:0] ccnt_q, ccnt_d;
  logic        r_trig_d;
  logic        trig_edge;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [2:0]  sel;

  assign trig_edge = i_trig && !r_trig_d;
  assign tx_valid  = (state_q == ST_SEND) && !last_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_FIN);

  // Message layout: rout hex[0..7], space, ccnt hex[9..16], CR, LF
  always_comb begin
    sel     = 3'd0;
    tx_data = ASCII_SP;
    if (byte_idx_q < 5'd8) begin
      sel     = 3'(5'd7 - byte_idx_q);
      tx_data = f_nib2ascii(rout_q[{sel, 2'b00} +: 4]);
    end else if (byte_idx_q == 5'd8) begin
      tx_data = ASCII_SP;
    end else if (byte_idx_q < 5'd17) begin
      sel     = 3'(5'd16 - byte_idx_q);
      tx_data = f_nib2ascii(ccnt_q[{sel, 2'b00} +: 4]);
    end else if (byte_idx_q == 5'd17) begin
      tx_data = ASCII_CR;
    end else begin
      tx_data = ASCII_LF;
    end
  end

  // last_q marks the final byte as handed over; FIN starts when its stop bit ends
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    last_d     = last_q;
    rout_d     = rout_q;
    ccnt_d     = ccnt_q;
    case (state_q)
      ST_IDLE: if (trig_edge) begin
        rout_d     = i_rout;
        ccnt_d     = i_ccnt;
        byte_idx_d = '0;
        last_d     = 1'b0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (last_q) begin
          if (tx_ready) state_d = ST_FIN;
        end else if (tx_ready) begin
          if (byte_idx_q == 5'(MSG_LEN - 1)) last_d = 1'b1;
          else                                byte_idx_d = byte_idx_q + 5'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      last_q     <= 1'b0;
      rout_q     <= '0;
      ccnt_q     <= '0;
      r_trig_d   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      last_q     <= last_d;
      rout_q     <= rout_d;
      ccnt_q     <= ccnt_d;
      r_trig_d   <= i_trig;
    end
  end

  m_UartTx #(.TX_COUNT(TX_COUNT)) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .i_valid (tx_valid),
    .i_data  (tx_data),
    .o_ready (tx_ready),
    .o_txd   (o_txd)
  );

endmodule
